// File: rtl/agu_ctx_encoder_if.sv
// AGU context-encoder port bundle: entry-write handshake, playback control and
// the context-word stream. The master drives the store; the slave is the encoder.
`timescale 1ns/1ps

interface agu_ctx_encoder_if #(
  parameter int WIDTH = 28,
  parameter int AW    = 4
);
  logic             clear;
  logic             wr_valid;
  logic             wr_ready;
  logic [3:0]       wr_op_code;
  logic [3:0]       wr_bus2mem_ld;
  logic [7:0]       wr_imm_val;
  logic             wr_pred_control;
  logic [3:0]       wr_select_pred;
  logic [3:0]       wr_bus2mem_st_addr;
  logic [3:0]       wr_bus2mem_st_data;
  logic             start;
  logic [7:0]       run_iters;
  logic [WIDTH:0]   outdata;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic [AW:0]      count;
  logic             err;

  modport master (
    output clear, wr_valid, wr_op_code, wr_bus2mem_ld, wr_imm_val,
           wr_pred_control, wr_select_pred, wr_bus2mem_st_addr,
           wr_bus2mem_st_data, start, run_iters,
    input  wr_ready, outdata, out_valid, busy, done, count, err
  );

  modport slave (
    input  clear, wr_valid, wr_op_code, wr_bus2mem_ld, wr_imm_val,
           wr_pred_control, wr_select_pred, wr_bus2mem_st_addr,
           wr_bus2mem_st_data, start, run_iters,
    output wr_ready, outdata, out_valid, busy, done, count, err
  );
endinterface

// File: rtl/agu_ctx_encoder.sv
// Packs AGU context entries into 29-bit words, holds them in a small store and
// replays the store onto the AGU context-word input a programmed number of times.
`timescale 1ns/1ps

module agu_ctx_encoder #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  agu_ctx_encoder_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [WIDTH:0] store [DEPTH];

  state_t         state, state_d;
  logic [AW:0]    count, count_d;
  logic [AW:0]    pc, pc_d;
  logic [7:0]     iter, iter_d;
  logic [WIDTH:0] outdata, outdata_d;
  logic           out_valid, out_valid_d;
  logic           done, done_d;
  logic           err, err_d;
  logic           store_we;
  logic           wr_fire;
  logic           wr_legal;
  logic [WIDTH:0] wr_word;

  function automatic logic onehot0(input logic [3:0] v);
    return (v & (v - 4'd1)) == 4'd0;
  endfunction

  assign wr_word = {bus.wr_bus2mem_st_data, bus.wr_bus2mem_st_addr,
                    bus.wr_select_pred, bus.wr_pred_control,
                    bus.wr_imm_val, bus.wr_bus2mem_ld, bus.wr_op_code};

  assign wr_legal = onehot0(bus.wr_bus2mem_ld)      && onehot0(bus.wr_select_pred) &&
                    onehot0(bus.wr_bus2mem_st_addr) && onehot0(bus.wr_bus2mem_st_data);

  assign bus.wr_ready = (state == IDLE) && (count < DEPTH_C) && !bus.start && !bus.clear;
  assign wr_fire      = bus.wr_valid && bus.wr_ready;

  // pc is the index of the next word to emit; pc == count marks the end of a pass.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d     = state;
    count_d     = count;
    pc_d        = pc;
    iter_d      = iter;
    outdata_d   = '0;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    err_d       = err;
    store_we    = 1'b0;

    if (bus.clear) begin
      state_d = IDLE;
      count_d = '0;
      pc_d    = '0;
      iter_d  = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (count != '0 && bus.run_iters != 8'd0) begin
              state_d     = RUN;
              outdata_d   = store[0];
              out_valid_d = 1'b1;
              pc_d        = ONE_C;
              iter_d      = bus.run_iters;
            end else begin
              done_d = 1'b1;
            end
          end else if (wr_fire) begin
            if (wr_legal) begin
              store_we = 1'b1;
              count_d  = count + ONE_C;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (pc == count) begin
            if (iter == 8'd1) begin
              state_d = IDLE;
              pc_d    = '0;
              iter_d  = '0;
              done_d  = 1'b1;
            end else begin
              outdata_d   = store[0];
              out_valid_d = 1'b1;
              pc_d        = ONE_C;
              iter_d      = iter - 8'd1;
            end
          end else begin
            outdata_d   = store[pc[AW-1:0]];
            out_valid_d = 1'b1;
            pc_d        = pc + ONE_C;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      count     <= '0;
      pc        <= '0;
      iter      <= '0;
      outdata   <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state     <= state_d;
      count     <= count_d;
      pc        <= pc_d;
      iter      <= iter_d;
      outdata   <= outdata_d;
      out_valid <= out_valid_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

  // NOTE: the store has no reset; count alone defines which entries are meaningful.
  always_ff @(posedge CLK) begin
    if (store_we) store[count[AW-1:0]] <= wr_word;
  end

  assign bus.outdata   = outdata;
  assign bus.out_valid = out_valid;
  assign bus.busy      = (state == RUN);
  assign bus.done      = done;
  assign bus.count     = count;
  assign bus.err       = err;

endmodule

// File: tb/tb_agu_ctx_encoder.sv
// Bench for agu_ctx_encoder: a queue-based store model predicts the whole output
// schedule of each playback, compared against the DUT on every falling edge.
`timescale 1ns/1ps

module tb_agu_ctx_encoder;
  localparam int WIDTH = 28;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef struct packed {
    logic [WIDTH:0] data;
    logic           valid;
    logic           busy;
    logic           done;
  } exp_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  always #5 CLK = ~CLK;

  agu_ctx_encoder_if #(.WIDTH(WIDTH), .AW(AW)) bus ();
  agu_ctx_encoder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus)
  );

  logic [WIDTH:0] mem_q[$];
  exp_t           exp_q[$];
  bit             m_err = 1'b0;
  bit             cur_busy = 1'b0;
  bit             chk_en = 1'b0;
  int             total = 0;
  int             bad = 0;
  int             valid_seen = 0;
  int             busy_seen = 0;
  int             done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [WIDTH:0] pack(input int op, ld, imm, pred, sel, sta, std);
    return (WIDTH+1)'(op + ld * 16 + imm * 256 + pred * 65536 +
                      sel * (1 << 17) + sta * (1 << 21) + std * (1 << 25));
  endfunction

  function automatic int rand_sel();
    case ($urandom_range(0, 3))
      0:       return 0;
      3:       return int'($urandom_range(0, 15));
      default: return 1 << $urandom_range(0, 3);
    endcase
  endfunction

  // Cycle-level expectations; an empty schedule means the idle state.
  always @(negedge CLK) begin
    exp_t e;
    if (chk_en) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      cur_busy = e.busy;
      check("outdata",   32'(bus.outdata),   32'(e.data));
      check("out_valid", 32'(bus.out_valid), 32'(e.valid));
      check("busy",      32'(bus.busy),      32'(e.busy));
      check("done",      32'(bus.done),      32'(e.done));
      check("count",     32'(bus.count),     32'(mem_q.size()));
      check("err",       32'(bus.err),       32'(m_err));
      check("wr_ready",  32'(bus.wr_ready),
            32'(!e.busy && mem_q.size() < DEPTH && !bus.start && !bus.clear));
      if (bus.out_valid) valid_seen++;
      if (bus.busy)      busy_seen++;
      if (bus.done)      done_seen++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_entry(input int op, ld, imm, pred, sel, sta, std);
    bus.wr_op_code         = 4'(op);
    bus.wr_bus2mem_ld      = 4'(ld);
    bus.wr_imm_val         = 8'(imm);
    bus.wr_pred_control    = 1'(pred);
    bus.wr_select_pred     = 4'(sel);
    bus.wr_bus2mem_st_addr = 4'(sta);
    bus.wr_bus2mem_st_data = 4'(std);
    bus.wr_valid           = 1'b1;
    @(posedge CLK);
    if (!cur_busy && mem_q.size() < DEPTH) begin
      if ($countones(4'(ld)) <= 1 && $countones(4'(sel)) <= 1 &&
          $countones(4'(sta)) <= 1 && $countones(4'(std)) <= 1)
        mem_q.push_back(pack(op, ld, imm, pred, sel, sta, std));
      else
        m_err = 1'b1;
    end
    #1;
    bus.wr_valid = 1'b0;
  endtask

  task automatic write_random(input bit legal_only);
    int ld, sel, sta, std;
    ld  = legal_only ? (1 << $urandom_range(0, 3)) : rand_sel();
    sel = legal_only ? 0 : rand_sel();
    sta = legal_only ? 0 : rand_sel();
    std = legal_only ? (1 << $urandom_range(0, 3)) : rand_sel();
    write_entry(int'($urandom_range(0, 2)), ld, int'($urandom_range(0, 255)),
                int'($urandom_range(0, 1)), sel, sta, std);
  endtask

  task automatic play(input int n);
    int sz;
    bus.start     = 1'b1;
    bus.run_iters = 8'(n);
    @(posedge CLK);
    if (!cur_busy) begin
      sz = mem_q.size();
      if (sz > 0 && n > 0)
        for (int it = 0; it < n; it++)
          for (int k = 0; k < sz; k++)
            exp_q.push_back('{data: mem_q[k], valid: 1'b1, busy: 1'b1, done: 1'b0});
      exp_q.push_back('{data: '0, valid: 1'b0, busy: 1'b0, done: 1'b1});
    end
    #1;
    bus.start = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    @(posedge CLK);
    mem_q.delete();
    exp_q.delete();
    m_err = 1'b0;
    #1;
    bus.clear = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) tick();
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int v0, b0, d0;
    bus.clear = 1'b0; bus.wr_valid = 1'b0; bus.start = 1'b0; bus.run_iters = 8'd0;
    bus.wr_op_code = '0; bus.wr_bus2mem_ld = '0; bus.wr_imm_val = '0;
    bus.wr_pred_control = 1'b0; bus.wr_select_pred = '0;
    bus.wr_bus2mem_st_addr = '0; bus.wr_bus2mem_st_data = '0;

    #2 RST_N = 1'b0;
    #10;
    check("rst_outdata",   32'(bus.outdata),   32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_done",      32'(bus.done),      32'd0);
    check("rst_count",     32'(bus.count),     32'd0);
    check("rst_err",       32'(bus.err),       32'd0);
    @(posedge CLK);
    #2 RST_N = 1'b1;
    chk_en = 1'b1;
    tick();

    // Single ld_i entry replayed once.
    write_entry(1, 1, 8'h5A, 0, 0, 0, 0);
    check("t1_count", 32'(bus.count), 32'd1);
    play(1);
    check("t1_word",  32'(bus.outdata),   32'h0005A11);
    check("t1_valid", 32'(bus.out_valid), 32'd1);
    tick();
    check("t1_done",      32'(bus.done),    32'd1);
    check("t1_done_data", 32'(bus.outdata), 32'd0);
    tick();
    check("t1_done_pulse", 32'(bus.done), 32'd0);

    // Three entries, two passes.
    do_clear();
    for (int i = 0; i < 3; i++) write_random(1'b1);
    v0 = valid_seen; b0 = busy_seen; d0 = done_seen;
    play(2);
    wait_idle();
    check("t2_valid_cycles", 32'(valid_seen - v0), 32'd6);
    check("t2_busy_cycles",  32'(busy_seen - b0),  32'd6);
    check("t2_done_pulses",  32'(done_seen - d0),  32'd1);

    // Illegal select field, then a legal entry, then clear.
    do_clear();
    write_entry(2, 0, 8'h11, 1, 4'b0110, 0, 0);
    check("t3_bad_count", 32'(bus.count), 32'd0);
    check("t3_bad_err",   32'(bus.err),   32'd1);
    write_entry(2, 0, 8'h22, 1, 4'b0100, 4'b0001, 4'b1000);
    check("t3_good_count", 32'(bus.count), 32'd1);
    check("t3_err_sticky", 32'(bus.err),   32'd1);
    do_clear();
    check("t3_clr_count", 32'(bus.count), 32'd0);
    check("t3_clr_err",   32'(bus.err),   32'd0);

    // Fill to DEPTH; a further write is refused without raising err.
    for (int i = 0; i < DEPTH; i++) write_random(1'b1);
    check("t4_full_count", 32'(bus.count),    32'd16);
    check("t4_full_ready", 32'(bus.wr_ready), 32'd0);
    write_random(1'b1);
    check("t4_over_count", 32'(bus.count), 32'd16);
    check("t4_over_err",   32'(bus.err),   32'd0);
    play(1);
    wait_idle();

    // Empty store, then zero iterations.
    do_clear();
    play(3);
    check("t5_empty_done",  32'(bus.done),      32'd1);
    check("t5_empty_valid", 32'(bus.out_valid), 32'd0);
    tick();
    write_random(1'b1);
    write_random(1'b1);
    play(0);
    check("t5_zero_done", 32'(bus.done), 32'd1);
    check("t5_zero_busy", 32'(bus.busy), 32'd0);
    tick();

    // Clear during the fifth output word aborts without a done pulse.
    do_clear();
    for (int i = 0; i < 4; i++) write_random(1'b1);
    play(3);
    repeat (4) tick();
    check("t6_fifth_valid", 32'(bus.out_valid), 32'd1);
    d0 = done_seen;
    do_clear();
    check("t6_clr_valid", 32'(bus.out_valid), 32'd0);
    check("t6_clr_busy",  32'(bus.busy),      32'd0);
    repeat (4) tick();
    check("t6_no_done", 32'(done_seen - d0), 32'd0);

    // Asynchronous reset mid-run.
    for (int i = 0; i < 3; i++) write_random(1'b1);
    play(5);
    tick();
    #2;
    RST_N = 1'b0;
    mem_q.delete();
    exp_q.delete();
    m_err = 1'b0;
    #1;
    check("t7_rst_outdata",   32'(bus.outdata),   32'd0);
    check("t7_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("t7_rst_busy",      32'(bus.busy),      32'd0);
    check("t7_rst_count",     32'(bus.count),     32'd0);
    @(posedge CLK);
    #2 RST_N = 1'b1;
    tick();

    // Randomized rounds, including ignored start/write requests during playback.
    for (int r = 0; r < 8; r++) begin
      do_clear();
      repeat ($urandom_range(1, 7)) write_random(1'b0);
      play(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) write_random(1'b1);
      if ($urandom_range(0, 1) == 1) play(2);
      wait_idle();
      tick();
      play(1);
      wait_idle();
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/agu_ctx_encoder.md
Name: agu_ctx_encoder

Overview:
- Packs field-level AGU context entries into WIDTH+1-bit context words and stores them in an internal context store.
- On command, streams the stored words one per cycle onto the AGU context-word input, looping a programmed number of times.
- Forms the producer end of the AGU context-word interface; the config loader sits upstream, and the AGU field decoder consumes `outdata` directly.

Parameters:
- WIDTH, 28, MSB index of the context word (word is WIDTH+1 = 29 bits).
- DEPTH, 16, number of context-store entries.
- AW, 4, entry-index width; DEPTH = 2**AW.

Ports:
- CLK  input  1  clock; all state changes on its rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous; empties store, clears err, aborts playback.
- wr_valid  input  1  write-entry request.
- wr_ready  output  1  entry accepted this cycle when wr_valid&wr_ready.
- wr_op_code  input  4  0001=ld_i, 0010=st_i, 0000=nop.
- wr_bus2mem_ld  input  4  load-address source PE select (one-hot or zero).
- wr_imm_val  input  8  immediate.
- wr_pred_control  input  1  predicated-entry flag.
- wr_select_pred  input  4  predicate source PE select (one-hot or zero).
- wr_bus2mem_st_addr  input  4  store-address source PE select (one-hot or zero).
- wr_bus2mem_st_data  input  4  store-data source PE select (one-hot or zero).
- start  input  1  begin playback (sampled in IDLE only).
- run_iters  input  8  passes over the store; sampled at start.
- outdata  output  WIDTH+1  registered context word to the AGU.
- out_valid  output  1  outdata holds a stored word.
- busy  output  1  high in RUN.
- done  output  1  one-cycle completion pulse.
- count  output  AW+1  entries stored (0..DEPTH).
- err  output  1  sticky: an entry was rejected.

Behaviour:
- Reset (RST_N low, asynchronous):
  - State is IDLE.
  - outdata=0, out_valid=0, busy=0, done=0, count=0, err=0, pc=0, iteration counter=0.
  - Store contents are don't-care.
- Packing (bit positions fixed):
  - op_code[3:0]
  - bus2mem_ld[7:4]
  - imm_val[15:8]
  - pred_control[16]
  - select_pred[20:17]
  - bus2mem_st_addr[24:21]
  - bus2mem_st_data[28:25]
- wr_ready:
  - Combinational: wr_ready = (state==IDLE) && (count<DEPTH) && !start && !clear.
- Write handshake:
  - On wr_valid&wr_ready with all four select fields zero or one-hot: the packed word is written to store[count] and count increments.
  - If any select field has two or more bits set, the handshake still completes but nothing is stored, count is unchanged and err is set to 1.
  - op_code is not checked.
- Full condition:
  - At count==DEPTH, wr_ready=0 and err is unchanged.
- Start in IDLE, count>0 and run_iters>0 (same edge):
  - State goes to RUN, busy=1.
  - outdata<=store[0], out_valid<=1, pc<=1.
  - The iteration counter is loaded with run_iters.
- RUN, each edge:
  - outdata<=store[pc].
  - pc wraps to 0 after count-1; on wrap the iteration counter decrements.
  - A stream of exactly count*run_iters consecutive valid words is emitted with no gaps.
  - The word emitted after the last one is 0, with out_valid=0.
- End of playback:
  - On the edge after the last word, outdata<=0, out_valid<=0, busy<=0 and done<=1 for one cycle.
  - State returns to IDLE.
  - The store is retained, so it can be replayed.
- Start in IDLE with count==0 or run_iters==0:
  - No words are emitted.
  - done pulses on the next edge; busy stays 0.
- start or wr_valid in RUN: ignored.
- clear (any state, highest priority after reset):
  - Next edge: count=0, err=0, outdata=0, out_valid=0, busy=0, pc=0, state is IDLE.
  - An aborted run produces no done pulse.
- clear together with start: clear wins.
- Idle output:
  - outdata is 0 (nop) whenever out_valid=0, so the downstream decoder always sees a nop.

Test Plan:
- Reset, then write op=0001, ld=0001, imm=0x5A, pred=0, sel=0, st_addr=0, st_data=0 -> count=1. Start with run_iters=1 -> the edge after start gives outdata=0x0005A11, out_valid=1 for 1 cycle, then done=1 for 1 cycle with outdata=0.
- Write 3 entries A,B,C, then start with run_iters=2 -> outdata A,B,C,A,B,C on 6 consecutive cycles, busy high for 6 cycles, done on the 7th.
- Write an entry with select_pred=0110 -> handshake completes, count unchanged, err=1. A following legal entry is stored; clear -> err=0, count=0.
- Write 16 legal entries -> wr_ready=0 at count=16. A 17th wr_valid is not accepted and err stays 0.
- Start with count=0 -> no out_valid, done pulses on the next cycle. Start with count=2, run_iters=0 -> same result.
- Mid-run clear (count=4, run_iters=3, clear asserted on the 5th output cycle) -> next cycle outdata=0, out_valid=0, busy=0, no done pulse. Assert RST_N low mid-run -> all outputs 0 immediately, without waiting for a clock edge.
